hit_judge: RTL and testbench

HIT_JUDGE -- requirements
Module: hit_judge

---
 rtl/game_pkg.sv | 22 ++
 rtl/lfsr8.sv | 21 ++
 rtl/hit_judge.sv | 157 +++++++++++++++
 tb/tb_hit_judge.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared types and constants for the reaction game.
// FSM encoding plus LFSR seed and feedback taps.
package game_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ACTIVE = 2'd2,
    S_COOL   = 2'd3
  } fsm_t;

  // taps 8,6,5,4 -> bits 7,5,4,3
  localparam logic [7:0] LFSR_SEED = 8'hA5;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  function automatic logic [7:0] lfsr_next(
    input logic [7:0] s
  );
    return {s[6:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/lfsr8.sv
// 8-bit Fibonacci LFSR, advances every cycle.
// Nonzero seed on a maximal polynomial keeps it off all-zero.
module lfsr8
  import game_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] q
);

  logic [7:0] r_q;

  // shift register with XOR feedback
  always_ff @(posedge clk) begin
    if (rst) r_q <= LFSR_SEED;
    else     r_q <= lfsr_next(r_q);
  end

  assign q = r_q;

endmodule

// File: rtl/hit_judge.sv
// Reaction-game hit judge: random delay, strike window, cooldown.
// Optional macro HIT_JUDGE_EARLY_PENALTY_EN penalises presses in WAIT.
module hit_judge
  import game_pkg::*;
#(
  parameter int TICK_DIV       = 100000,
  parameter int MIN_DELAY      = 20,
  parameter int WINDOW_TICKS   = 50,
  parameter int COOLDOWN_TICKS = 30
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn,
  input  logic [3:0] state,
  output logic       hit,
  output logic       damage,
  output logic       enemy
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int TW = 16;

  logic [PW-1:0] r_presc;
  logic          w_tick;
  logic          r_btn_q;
  logic          w_rise;
  logic          w_play;
  logic [7:0]    w_lfsr;
  logic          w_unused_lfsr;
  logic [TW-1:0] w_delay;
  logic [TW-1:0] r_timer;
  logic [TW-1:0] w_timer_nx;
  logic          w_tmr_zero;
  fsm_t          r_fsm;
  fsm_t          w_fsm_nx;
  logic          w_hit_nx;
  logic          w_dmg_nx;
  logic          w_enemy_nx;
  logic          r_hit;
  logic          r_dmg;
  logic          r_enemy;

  lfsr8 u_lfsr (
    .clk (clk),
    .rst (rst),
    .q   (w_lfsr)
  );

  assign w_unused_lfsr = ^w_lfsr[7:4];

  assign w_tick     = (r_presc == PW'(TICK_DIV - 1));
  assign w_rise     = btn & ~r_btn_q;
  assign w_play     = (state != 4'd0);
  assign w_tmr_zero = (r_timer == '0);
  assign w_delay    = TW'(MIN_DELAY) + TW'(w_lfsr[3:0]);

  // game-tick prescaler
  always_ff @(posedge clk) begin
    if (rst)         r_presc <= '0;
    else if (w_tick) r_presc <= '0;
    else             r_presc <= r_presc + PW'(1);
  end

  // button edge detector history
  always_ff @(posedge clk) begin
    if (rst) r_btn_q <= 1'b0;
    else     r_btn_q <= btn;
  end

  // FSM state, timer and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_fsm   <= S_IDLE;
      r_timer <= '0;
      r_hit   <= 1'b0;
      r_dmg   <= 1'b0;
      r_enemy <= 1'b0;
    end else begin
      r_fsm   <= w_fsm_nx;
      r_timer <= w_timer_nx;
      r_hit   <= w_hit_nx;
      r_dmg   <= w_dmg_nx;
      r_enemy <= w_enemy_nx;
    end
  end

  // next state and timer
  always_comb begin
    w_fsm_nx   = r_fsm;
    w_timer_nx = r_timer;
    if (!w_play) begin
      w_fsm_nx = S_IDLE;
    end else begin
      unique case (r_fsm)
        S_IDLE: begin
          w_fsm_nx   = S_WAIT;
          w_timer_nx = w_delay;
        end
        S_WAIT: begin
          if (w_tick) begin
            if (w_tmr_zero) begin
              w_fsm_nx   = S_ACTIVE;
              w_timer_nx = TW'(WINDOW_TICKS);
            end else begin
              w_timer_nx = r_timer - TW'(1);
            end
          end
`ifdef HIT_JUDGE_EARLY_PENALTY_EN
          // early press restarts the wait
          if (w_rise) begin
            w_fsm_nx   = S_WAIT;
            w_timer_nx = w_delay;
          end
`endif
        end
        S_ACTIVE: begin
          if (w_rise || (w_tick && w_tmr_zero)) begin
            w_fsm_nx   = S_COOL;
            w_timer_nx = TW'(COOLDOWN_TICKS);
          end else if (w_tick) begin
            w_timer_nx = r_timer - TW'(1);
          end
        end
        S_COOL: begin
          if (w_tick) begin
            if (w_tmr_zero) begin
              w_fsm_nx   = S_WAIT;
              w_timer_nx = w_delay;
            end else begin
              w_timer_nx = r_timer - TW'(1);
            end
          end
        end
        default: begin
          w_fsm_nx = S_IDLE;
        end
      endcase
    end
  end

  // outcome pulses; strike wins over expiry
  always_comb begin
    w_hit_nx = w_play && (r_fsm == S_ACTIVE) && w_rise;
    w_dmg_nx = w_play && (r_fsm == S_ACTIVE) && !w_rise
               && w_tick && w_tmr_zero;
`ifdef HIT_JUDGE_EARLY_PENALTY_EN
    if (w_play && (r_fsm == S_WAIT) && w_rise)
      w_dmg_nx = 1'b1;
`endif
    w_enemy_nx = (w_fsm_nx == S_ACTIVE);
  end

  assign hit    = r_hit;
  assign damage = r_dmg;
  assign enemy  = r_enemy;

endmodule

// File: tb/tb_hit_judge.sv
// Self-checking bench for hit_judge: directed scenarios
// plus random stimulus against a cycle-level game model.
module tb_hit_judge;

  localparam int TD = 4;
  localparam int MD = 2;
  localparam int WT = 5;
  localparam int CT = 3;

`ifdef HIT_JUDGE_EARLY_PENALTY_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       btn;
  logic [3:0] state;
  logic       hit;
  logic       damage;
  logic       enemy;

  int n_chk = 0;
  int n_err = 0;

  hit_judge #(
    .TICK_DIV       (TD),
    .MIN_DELAY      (MD),
    .WINDOW_TICKS   (WT),
    .COOLDOWN_TICKS (CT)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .btn    (btn),
    .state  (state),
    .hit    (hit),
    .damage (damage),
    .enemy  (enemy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // behavioural game model: 0 idle, 1 waiting, 2 enemy up, 3 rest
  int       m_mode;
  int       m_timer;
  int       m_presc;
  bit [7:0] m_rng;
  bit       m_prev;
  bit       m_hit, m_dmg, m_enemy;

  task automatic m_step();
    bit tick, rise;
    int rnd;
    if (rst) begin
      m_mode = 0; m_timer = 0; m_presc = 0;
      m_rng = 8'hA5; m_prev = 0;
      m_hit = 0; m_dmg = 0; m_enemy = 0;
      return;
    end
    tick  = (m_presc == TD - 1);
    rise  = btn && !m_prev;
    rnd   = MD + int'(m_rng % 16);
    m_hit = 0;
    m_dmg = 0;
    if (state == 0) begin
      m_mode = 0;
    end else if (m_mode == 0) begin
      m_mode = 1; m_timer = rnd;
    end else if (m_mode == 1) begin
      if (EARLY && rise) begin
        m_dmg = 1; m_timer = rnd;
      end else if (tick) begin
        if (m_timer == 0) begin m_mode = 2; m_timer = WT; end
        else m_timer--;
      end
    end else if (m_mode == 2) begin
      if (rise) begin
        m_hit = 1; m_mode = 3; m_timer = CT;
      end else if (tick && m_timer == 0) begin
        m_dmg = 1; m_mode = 3; m_timer = CT;
      end else if (tick) begin
        m_timer--;
      end
    end else begin
      if (tick) begin
        if (m_timer == 0) begin m_mode = 1; m_timer = rnd; end
        else m_timer--;
      end
    end
    m_enemy = (m_mode == 2);
    m_presc = tick ? 0 : m_presc + 1;
    m_rng   = {m_rng[6:0], m_rng[7] ^ m_rng[5] ^ m_rng[4] ^ m_rng[3]};
    m_prev  = btn;
  endtask

  task automatic cyc();
    m_step();
    @(posedge clk);
    #1;
    chk("hit", hit, m_hit);
    chk("damage", damage, m_dmg);
    chk("enemy", enemy, m_enemy);
    chk("excl", hit & damage, 0);
  endtask

  task automatic wait_enemy(input int lim, output int n);
    n = 0;
    while (enemy !== 1'b1 && n < lim) begin
      cyc();
      n++;
    end
    chk("enemy_seen", enemy, 1);
  endtask

  int n, cnt, hits, dmgs, off;

  initial begin
    rst = 1; btn = 0; state = 4'd1;
    for (int i = 0; i < 3; i++) cyc();
    chk("rst_hit", hit, 0);
    chk("rst_dmg", damage, 0);
    chk("rst_enemy", enemy, 0);
    rst = 0;

    wait_enemy((MD + 15 + 1) * TD + 4, n);

    // strike two cycles into the window
    cyc(); cyc();
    btn = 1;
    cyc();
    chk("hit_pulse", hit, 1);
    chk("hit_nodmg", damage, 0);
    cyc();
    chk("hit_once", hit, 0);
    chk("hit_enemy_off", enemy, 0);

    // keep holding: next window must not register a strike
    wait_enemy(120, n);
    chk("cool_gap", (n + 1 >= CT * TD), 1);
    hits = 0; dmgs = 0; cnt = 0;
    while (dmgs == 0 && cnt < 30) begin
      cyc(); cnt++;
      hits += hit; dmgs += damage;
    end
    chk("held_nohit", hits, 0);
    chk("held_dmg", dmgs, 1);
    btn = 0;

    // miss: damage a full window after the enemy shows
    cyc();
    wait_enemy(120, n);
    hits = 0; cnt = 0;
    while (damage !== 1'b1 && cnt < 40) begin
      cyc(); cnt++;
      hits += hit;
    end
    chk("miss_delay", cnt, (WT + 1) * TD);
    chk("miss_nohit", hits, 0);
    cyc();
    chk("miss_once", damage, 0);

    // early press inside WAIT
    for (int i = 0; i < 16; i++) cyc();
    btn = 1;
    cyc();
    chk("early_dmg", damage, EARLY);
    chk("early_enemy", enemy, 0);
    cyc();
    chk("early_once", damage, 0);
    btn = 0;

    // stop the game mid-window
    wait_enemy(200, n);
    state = 0;
    cyc();
    chk("stop_enemy", enemy, 0);
    hits = 0; dmgs = 0;
    for (int i = 0; i < 200; i++) begin
      btn = ($urandom_range(0, 3) == 0);
      cyc();
      hits += hit; dmgs += damage;
    end
    chk("stop_hits", hits, 0);
    chk("stop_dmgs", dmgs, 0);
    btn = 0;
    state = 4'd1;
    wait_enemy((MD + 15 + 1) * TD + 8, n);

    // randomized run against the model
    off = 0;
    for (int i = 0; i < 5000; i++) begin
      if ($urandom_range(0, 5) == 0) btn = ~btn;
      if (off == 0 && $urandom_range(0, 399) == 0)
        off = $urandom_range(1, 30);
      if (off > 0) begin
        state = 0; off--;
      end else begin
        state = 4'($urandom_range(1, 15));
      end
      rst = ($urandom_range(0, 599) == 0);
      cyc();
    end
    rst = 0;

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
